// File: rtl/sccb_arbiter_pkg.sv
// Shared definitions for the SCCB arbiter: FSM state codes, owner codes
// and default parameter values.
package sccb_arbiter_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 1000000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/sccb_arbiter_if.sv
// Bundle of the two requester ports and the SCCB master port.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (requesters plus SCCB master).
interface sccb_arbiter_if import sccb_arbiter_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) ();

  // requester A
  logic              a_wr_req;
  logic              a_rd_req;
  logic [DATA_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              a_done;
  logic              a_err;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rdata_vld;

  // requester B
  logic              b_wr_req;
  logic              b_rd_req;
  logic [DATA_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic              b_done;
  logic              b_err;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rdata_vld;

  // SCCB master side
  logic              m_wr_en;
  logic              m_rd_en;
  logic [DATA_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rdy;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rdata_vld;

  modport slave (
    input  a_wr_req, a_rd_req, a_addr, a_wdata,
    output a_ack, a_done, a_err, a_rdata, a_rdata_vld,
    input  b_wr_req, b_rd_req, b_addr, b_wdata,
    output b_ack, b_done, b_err, b_rdata, b_rdata_vld,
    output m_wr_en, m_rd_en, m_addr, m_wdata,
    input  m_rdy, m_rdata, m_rdata_vld
  );

  modport master (
    output a_wr_req, a_rd_req, a_addr, a_wdata,
    input  a_ack, a_done, a_err, a_rdata, a_rdata_vld,
    output b_wr_req, b_rd_req, b_addr, b_wdata,
    input  b_ack, b_done, b_err, b_rdata, b_rdata_vld,
    input  m_wr_en, m_rd_en, m_addr, m_wdata,
    output m_rdy, m_rdata, m_rdata_vld
  );

endinterface

// File: rtl/sccb_arbiter.sv
// Two-requester round-robin arbiter in front of a single SCCB master.
// A transaction is granted in IDLE, issued as a one-cycle enable pulse,
// tracked through the master's busy window and closed with a done pulse
// (plus err if the master never finishes within TIMEOUT cycles).
// rst_n is synchronous and active-high despite its name.
module sccb_arbiter import sccb_arbiter_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  sccb_arbiter_if.slave bus,
  output logic          busy
);

  // Counter just wide enough to hold TIMEOUT-1 (TIMEOUT must be >= 2).
  localparam int CNT_W = $clog2(TIMEOUT);
  // The jump to FINISH is taken while the counter holds TIMEOUT-2, so the
  // counter lands on TIMEOUT-1 as err/done appear.
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT - 2);

  state_t            state_reg, state_next;
  owner_t            owner_reg, last_grant_reg, grant_sel;
  logic [CNT_W-1:0]  cnt_reg;

  logic              a_any, b_any;
  logic              sel_wr;
  logic [DATA_W-1:0] sel_addr, sel_wdata;
  logic              start, timeout_hit, in_wait, finish_enter;

  logic              a_ack_reg, b_ack_reg;
  logic              a_done_reg, b_done_reg;
  logic              a_err_reg, b_err_reg;
  logic              a_vld_reg, b_vld_reg;
  logic              m_wr_en_reg, m_rd_en_reg;
  logic [DATA_W-1:0] m_addr_reg, m_wdata_reg;
  logic [DATA_W-1:0] a_rdata_reg, b_rdata_reg;

  assign a_any   = bus.a_wr_req | bus.a_rd_req;
  assign b_any   = bus.b_wr_req | bus.b_rd_req;
  assign in_wait = (state_reg == ST_WAIT_BUSY) || (state_reg == ST_WAIT_DONE);

  // Round-robin winner and its operation; write beats read for one requester.
  always_comb begin
    grant_sel = OWN_A;
    if (a_any && b_any) begin
      grant_sel = (last_grant_reg == OWN_A) ? OWN_B : OWN_A;
    end else if (b_any) begin
      grant_sel = OWN_B;
    end

    sel_wr    = bus.a_wr_req;
    sel_addr  = bus.a_addr;
    sel_wdata = bus.a_wdata;
    if (grant_sel == OWN_B) begin
      sel_wr    = bus.b_wr_req;
      sel_addr  = bus.b_addr;
      sel_wdata = bus.b_wdata;
    end
  end

  // Next-state logic; unknown state codes fall back to IDLE.
  always_comb begin
    state_next   = state_reg;
    start        = 1'b0;
    timeout_hit  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if ((a_any || b_any) && bus.m_rdy) begin
          state_next = ST_ISSUE;
          start      = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (cnt_reg == CNT_PRE) begin
          state_next  = ST_FINISH;
          timeout_hit = 1'b1;
        end else if (!bus.m_rdy) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A real completion wins over a simultaneous timeout.
        if (bus.m_rdy) begin
          state_next = ST_FINISH;
        end else if (cnt_reg == CNT_PRE) begin
          state_next  = ST_FINISH;
          timeout_hit = 1'b1;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign finish_enter = in_wait && (state_next == ST_FINISH);

  // State register and transaction timeout counter.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_ISSUE) begin
        cnt_reg <= '0;
      end else if (in_wait && (state_next != ST_FINISH)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else if (timeout_hit) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Latch the granted request; address/data are held until the next grant.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      owner_reg      <= OWN_A;
      last_grant_reg <= OWN_B;
      m_addr_reg     <= '1;
      m_wdata_reg    <= '0;
    end else if (start) begin
      owner_reg      <= grant_sel;
      last_grant_reg <= grant_sel;
      m_addr_reg     <= sel_addr;
      m_wdata_reg    <= sel_wdata;
    end
  end

  // One-cycle handshake pulses: ack/enable on issue, done/err on finish.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_ack_reg   <= 1'b0;
      b_ack_reg   <= 1'b0;
      m_wr_en_reg <= 1'b0;
      m_rd_en_reg <= 1'b0;
      a_done_reg  <= 1'b0;
      b_done_reg  <= 1'b0;
      a_err_reg   <= 1'b0;
      b_err_reg   <= 1'b0;
    end else begin
      a_ack_reg   <= start && (grant_sel == OWN_A);
      b_ack_reg   <= start && (grant_sel == OWN_B);
      m_wr_en_reg <= start && sel_wr;
      m_rd_en_reg <= start && !sel_wr;
      a_done_reg  <= finish_enter && (owner_reg == OWN_A);
      b_done_reg  <= finish_enter && (owner_reg == OWN_B);
      a_err_reg   <= timeout_hit && (owner_reg == OWN_A);
      b_err_reg   <= timeout_hit && (owner_reg == OWN_B);
    end
  end

  // Route master read data to the current owner only, one cycle later.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_vld_reg   <= 1'b0;
      b_vld_reg   <= 1'b0;
      a_rdata_reg <= '0;
      b_rdata_reg <= '0;
    end else begin
      a_vld_reg <= 1'b0;
      b_vld_reg <= 1'b0;
      if (in_wait && bus.m_rdata_vld) begin
        if (owner_reg == OWN_A) begin
          a_rdata_reg <= bus.m_rdata;
          a_vld_reg   <= 1'b1;
        end else begin
          b_rdata_reg <= bus.m_rdata;
          b_vld_reg   <= 1'b1;
        end
      end
    end
  end

  assign busy            = (state_reg != ST_IDLE);

  assign bus.a_ack       = a_ack_reg;
  assign bus.a_done      = a_done_reg;
  assign bus.a_err       = a_err_reg;
  assign bus.a_rdata     = a_rdata_reg;
  assign bus.a_rdata_vld = a_vld_reg;

  assign bus.b_ack       = b_ack_reg;
  assign bus.b_done      = b_done_reg;
  assign bus.b_err       = b_err_reg;
  assign bus.b_rdata     = b_rdata_reg;
  assign bus.b_rdata_vld = b_vld_reg;

  assign bus.m_wr_en     = m_wr_en_reg;
  assign bus.m_rd_en     = m_rd_en_reg;
  assign bus.m_addr      = m_addr_reg;
  assign bus.m_wdata     = m_wdata_reg;

endmodule
